// File: rtl/dsi_tx_line_buffer.sv
// rtl/dsi_tx_line_buffer.sv - show-ahead pixel line buffer with line-ready, flush and sticky protocol-error flags
module dsi_tx_line_buffer #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH_LOG2      = 8,
  parameter int READY_MARGIN    = 16,
  parameter int LINE_MODE       = 0,
  parameter int THRESHOLD_BYTES = 640
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] avl_st_in_data,
  input  logic                  avl_st_in_valid,
  input  logic                  avl_st_in_startofpacket,
  input  logic                  avl_st_in_endofpacket,
  output logic                  avl_st_in_ready,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_sop,
  output logic                  fifo_eop,
  output logic                  fifo_not_empty,
  output logic                  fifo_line_ready,
  input  logic                  fifo_read_ack,
  output logic [DEPTH_LOG2:0]   fifo_usedw,
  output logic [DEPTH_LOG2:0]   lines_stored,
  input  logic                  flush,
  input  logic                  err_clear,
  output logic                  underflow_err,
  output logic                  overflow_err,
  output logic                  framing_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int TW = THRESHOLD_BYTES / BEAT_BYTES;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int WW = DATA_WIDTH + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - READY_MARGIN);
  localparam logic [CW-1:0] TW_C = CW'(TW);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WW-1:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         usedw_q, usedw_d, lines_q, lines_d;
  logic                  in_pkt_q, in_pkt_d;
  logic                  ready_q, ready_d, line_ready_q, line_ready_d;
  logic                  under_q, under_d, over_q, over_d, frame_q, frame_d;

  logic          empty, full, accept, wr, rd;
  logic          under_ev, over_ev, frame_ev;
  logic [WW-1:0] head;

  always_comb begin
    empty  = (usedw_q == '0);
    full   = (usedw_q == DEPTH_C);
    head   = mem_q[rd_ptr_q];
    accept = avl_st_in_valid & ready_q;
    wr     = accept & ~full;
    rd     = fifo_read_ack & ~empty;

    // Events coinciding with a flush are dropped along with the data they carry.
    over_ev  = accept & full & ~flush;
    under_ev = fifo_read_ack & empty & ~flush;
    frame_ev = wr & ~flush &
               (avl_st_in_startofpacket ? in_pkt_q : ~in_pkt_q);

    under_d = under_ev | (under_q & ~err_clear);
    over_d  = over_ev  | (over_q  & ~err_clear);
    frame_d = frame_ev | (frame_q & ~err_clear);

    ready_d      = (usedw_q < READY_LIM);
    line_ready_d = (LINE_MODE != 0) ? (lines_q != '0) : (usedw_q >= TW_C);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    lines_d  = lines_q;
    in_pkt_d = in_pkt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      lines_d  = '0;
      in_pkt_d = 1'b0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd) rd_ptr_d = rd_ptr_q + PTR_ONE;

      if (wr && !rd)      usedw_d = usedw_q + CNT_ONE;
      else if (rd && !wr) usedw_d = usedw_q - CNT_ONE;

      if ((wr & avl_st_in_endofpacket) && !(rd & head[WW-1]))
        lines_d = lines_q + CNT_ONE;
      else if ((rd & head[WW-1]) && !(wr & avl_st_in_endofpacket))
        lines_d = lines_q - CNT_ONE;

      if (wr) begin
        if (avl_st_in_endofpacket)        in_pkt_d = 1'b0;
        else if (avl_st_in_startofpacket) in_pkt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr && !flush)
      mem_q[wr_ptr_q] <= {avl_st_in_endofpacket, avl_st_in_startofpacket, avl_st_in_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      usedw_q      <= '0;
      lines_q      <= '0;
      in_pkt_q     <= 1'b0;
      ready_q      <= 1'b0;
      line_ready_q <= 1'b0;
      under_q      <= 1'b0;
      over_q       <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      usedw_q      <= usedw_d;
      lines_q      <= lines_d;
      in_pkt_q     <= in_pkt_d;
      ready_q      <= ready_d;
      line_ready_q <= line_ready_d;
      under_q      <= under_d;
      over_q       <= over_d;
      frame_q      <= frame_d;
    end
  end

  // The array is never reset, so the head view is masked while empty.
  assign fifo_data       = empty ? '0 : head[DATA_WIDTH-1:0];
  assign fifo_sop        = ~empty & head[DATA_WIDTH];
  assign fifo_eop        = ~empty & head[DATA_WIDTH+1];
  assign fifo_not_empty  = ~empty;
  assign fifo_usedw      = usedw_q;
  assign lines_stored    = lines_q;
  assign avl_st_in_ready = ready_q;
  assign fifo_line_ready = line_ready_q;
  assign underflow_err   = under_q;
  assign overflow_err    = over_q;
  assign framing_err     = frame_q;

endmodule

// File: tb/tb_dsi_tx_line_buffer.sv
// tb/tb_dsi_tx_line_buffer.sv - randomized self-checking bench with a queue-based reference model
module tb_dsi_tx_line_buffer;

  localparam int DW = 32;
  localparam int DL = 8;
  localparam int DEPTH = 256;
  localparam int MARGIN = 16;
  localparam int TW = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, valid, sop, eop, ack, flush, err_clear;
  logic [DW-1:0] data;

  logic          ready0, ne0, lr0, un0, ov0, fr0, sop0, eop0;
  logic [DW-1:0] fdata0;
  logic [DL:0]   usedw0, lines0;
  logic          ready1, ne1, lr1, un1, ov1, fr1, sop1, eop1;
  logic [DW-1:0] fdata1;
  logic [DL:0]   usedw1, lines1;

  dsi_tx_line_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .READY_MARGIN(MARGIN),
                       .LINE_MODE(0), .THRESHOLD_BYTES(640)) u0 (
    .clk(clk), .rst_n(rst_n), .avl_st_in_data(data), .avl_st_in_valid(valid),
    .avl_st_in_startofpacket(sop), .avl_st_in_endofpacket(eop), .avl_st_in_ready(ready0),
    .fifo_data(fdata0), .fifo_sop(sop0), .fifo_eop(eop0), .fifo_not_empty(ne0),
    .fifo_line_ready(lr0), .fifo_read_ack(ack), .fifo_usedw(usedw0), .lines_stored(lines0),
    .flush(flush), .err_clear(err_clear), .underflow_err(un0), .overflow_err(ov0),
    .framing_err(fr0));

  dsi_tx_line_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .READY_MARGIN(MARGIN),
                       .LINE_MODE(1), .THRESHOLD_BYTES(640)) u1 (
    .clk(clk), .rst_n(rst_n), .avl_st_in_data(data), .avl_st_in_valid(valid),
    .avl_st_in_startofpacket(sop), .avl_st_in_endofpacket(eop), .avl_st_in_ready(ready1),
    .fifo_data(fdata1), .fifo_sop(sop1), .fifo_eop(eop1), .fifo_not_empty(ne1),
    .fifo_line_ready(lr1), .fifo_read_ack(ack), .fifo_usedw(usedw1), .lines_stored(lines1),
    .flush(flush), .err_clear(err_clear), .underflow_err(un1), .overflow_err(ov1),
    .framing_err(fr1));

  // Reference model: a queue of {eop, sop, data} words plus registered flags.
  logic [DW+1:0] q[$];
  bit m_ready, m_lr0, m_lr1, m_un, m_ov, m_fr, m_in_pkt;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int count_eops();
    int n = 0;
    foreach (q[i]) if (q[i][DW+1]) n++;
    return n;
  endfunction

  task automatic model_update();
    int sz = q.size();
    bit nr = (sz < DEPTH - MARGIN);
    bit nlr0 = (sz >= TW);
    bit nlr1 = (count_eops() != 0);
    bit acc, wr, rd;
    if (!rst_n) begin
      q.delete();
      m_in_pkt = 0; m_ready = 0; m_lr0 = 0; m_lr1 = 0;
      m_un = 0; m_ov = 0; m_fr = 0;
      return;
    end
    acc = valid & m_ready;
    wr  = acc & (sz != DEPTH);
    rd  = ack & (sz != 0);
    m_ov = (acc & (sz == DEPTH) & !flush) | (m_ov & !err_clear);
    m_un = (ack & (sz == 0) & !flush) | (m_un & !err_clear);
    m_fr = (wr & !flush & (sop ? m_in_pkt : !m_in_pkt)) | (m_fr & !err_clear);
    if (flush) begin
      q.delete();
      m_in_pkt = 0;
    end else begin
      if (rd) void'(q.pop_front());
      if (wr) begin
        q.push_back({eop, sop, data});
        if (eop) m_in_pkt = 0;
        else if (sop) m_in_pkt = 1;
      end
    end
    m_ready = nr; m_lr0 = nlr0; m_lr1 = nlr1;
  endtask

  task automatic check_all();
    logic [DW+1:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    check("ready", ready0, m_ready);
    check("not_empty", ne0, q.size() != 0);
    check("usedw", usedw0, q.size());
    check("lines", lines0, count_eops());
    check("head_data", fdata0, h[DW-1:0]);
    check("head_sop", sop0, h[DW]);
    check("head_eop", eop0, h[DW+1]);
    check("line_ready_m0", lr0, m_lr0);
    check("line_ready_m1", lr1, m_lr1);
    check("underflow", un0, m_un);
    check("overflow", ov0, m_ov);
    check("framing", fr0, m_fr);
    check("usedw_m1", usedw1, q.size());
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic beat(input bit s, input bit e);
    valid = 1; sop = s; eop = e; data = $urandom;
    cyc();
    valid = 0; sop = 0; eop = 0;
  endtask

  initial begin
    int wrote;
    int budget;
    rst_n = 0; valid = 0; sop = 0; eop = 0; ack = 0; flush = 0; err_clear = 0; data = '0;
    repeat (3) cyc();
    check("ready_in_reset", ready0, 0);
    rst_n = 1;
    cyc();
    check("ready_after_release", ready0, 1);

    // Threshold mode: 159 beats keep line_ready low, the 160th raises it two edges later.
    for (int i = 0; i < TW - 1; i++) beat(i == 0, 0);
    cyc(); cyc();
    check("lr_below_tw", lr0, 0);
    beat(0, 0);
    check("usedw_at_tw", usedw0, TW);
    check("lr_one_edge", lr0, 0);
    cyc();
    check("lr_two_edges", lr0, 1);
    flush = 1; cyc(); flush = 0; cyc();

    // Complete-line mode: one 4-beat line then drain it.
    for (int i = 0; i < 4; i++) beat(i == 0, i == 3);
    cyc(); cyc();
    check("lines_one", lines0, 1);
    check("lr_line_mode", lr1, 1);
    for (int i = 0; i < 4; i++) begin
      check("pop_eop", eop0, i == 3);
      ack = 1; cyc(); ack = 0;
    end
    check("lines_zero", lines0, 0);
    cyc();

    // Continuous stream without reads stops on the ready margin.
    for (int i = 0; i < 270; i++) begin
      valid = 1; sop = !m_in_pkt; eop = ($urandom_range(7) == 0); data = $urandom;
      cyc();
    end
    valid = 0; sop = 0; eop = 0;
    check("usedw_capped", usedw0, DEPTH - MARGIN + 1);
    check("no_overflow", ov0, 0);
    check("ready_low", ready0, 0);

    // Concurrent read/write across the pointer wrap.
    wrote = 0;
    budget = 0;
    while (wrote < 1000 && budget < 6000) begin
      bit acc;
      valid = ($urandom_range(3) != 0);
      ack = (q.size() != 0) && ($urandom_range(3) != 0);
      sop = !m_in_pkt; eop = ($urandom_range(5) == 0); data = $urandom;
      acc = valid && m_ready && (q.size() < DEPTH);
      cyc();
      if (acc) wrote++;
      budget++;
    end
    valid = 0; ack = 0; sop = 0; eop = 0;
    check("stream_budget", wrote >= 1000, 1);
    budget = 0;
    while (q.size() != 0 && budget < 400) begin
      ack = 1; cyc(); budget++;
    end
    ack = 0;
    check("drained", ne0, 0);
    check("no_overflow_stream", ov0, 0);
    flush = 1; cyc(); flush = 0; cyc();

    // Error flags.
    ack = 1; cyc(); ack = 0;
    check("underflow_set", un0, 1);
    beat(1, 0);
    beat(1, 0);
    check("framing_set", fr0, 1);
    err_clear = 1; cyc(); err_clear = 0;
    check("underflow_clr", un0, 0);
    check("framing_clr", fr0, 0);
    flush = 1; cyc(); flush = 0;

    // Flush with 37 words and 2 lines stored, plus a concurrent write.
    ack = 1; cyc(); ack = 0;
    for (int i = 0; i < 10; i++) beat(i == 0, i == 9);
    for (int i = 0; i < 15; i++) beat(i == 0, i == 14);
    for (int i = 0; i < 12; i++) beat(i == 0, 0);
    check("usedw_37", usedw0, 37);
    check("lines_2", lines0, 2);
    flush = 1; valid = 1; sop = 1; data = $urandom;
    cyc();
    flush = 0; valid = 0; sop = 0;
    check("flush_usedw", usedw0, 0);
    check("flush_lines", lines0, 0);
    check("flush_ne", ne0, 0);
    check("flush_keeps_err", un0, 1);
    err_clear = 1; cyc(); err_clear = 0;

    // Simultaneous read and write at empty: write stored, read flagged.
    ack = 1; beat(1, 1); ack = 0;
    check("rw_empty_usedw", usedw0, 1);
    check("rw_empty_under", un0, 1);
    cyc();

    // Reset mid-operation clears contents and flags.
    rst_n = 0; cyc();
    check("rst_usedw", usedw0, 0);
    check("rst_under", un0, 0);
    check("rst_ready", ready0, 0);
    rst_n = 1; cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
